exc_ctrl: RTL and testbench

- Tracks synchronous exceptions of each in-flight instruction from ID through MEM, and synchronizes and latches the six hardware interrupt lines.
- Presents one prioritized `exc_type` plus the `hard_int` vector to cp0 each cycle.
- Consumes cp0's `int_signal`/`eret_signal` and runs the pipeline flush sequence.
- Sits between the ID/EXE/MEM stage logic and cp0.

---
 rtl/exc_ctrl_pkg.sv | 19 +
 rtl/exc_ctrl_int_sync.sv | 29 ++
 rtl/exc_ctrl.sv | 122 ++++++++++++
 tb/tb_exc_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// rtl/exc_ctrl_pkg.sv - exception codes and FSM encodings shared by exc_ctrl and cp0
package exc_ctrl_pkg;

   localparam int EXC_TYPE_LENGTH = 5;

   localparam logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_INT  = 5'h00;
   localparam logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_SYS  = 5'h08;
   localparam logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_RI   = 5'h0A;
   localparam logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_OV   = 5'h0C;
   localparam logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_TR   = 5'h0D;
   localparam logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_ERET = 5'h10;
   localparam logic [EXC_TYPE_LENGTH-1:0] EXC_TYPE_NONE = 5'h1F;

   typedef enum logic {
      EXC_CTRL_RUN   = 1'b0,
      EXC_CTRL_FLUSH = 1'b1
   } exc_ctrl_state_e;

endpackage

// File: rtl/exc_ctrl_int_sync.sv
// rtl/exc_ctrl_int_sync.sv - 6-bit two-flop synchronizer for the hardware interrupt lines
module exc_ctrl_int_sync (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] d,
   output logic [5:0] q
);

   logic [5:0] meta_q, meta_d;
   logic [5:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/exc_ctrl.sv
// rtl/exc_ctrl.sv - exception tracking, interrupt latching and flush sequencing for cp0
// Optional: EXC_CTRL_INT_SYNC_EN adds a two-flop synchronizer on hard_int_raw.
module exc_ctrl
   import exc_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [5:0]                 hard_int_raw,
   input  logic [EXC_TYPE_LENGTH-1:0] exc_id,
   input  logic [EXC_TYPE_LENGTH-1:0] exc_exe,
   input  logic                       stall,
   input  logic                       bubble_id,
   input  logic                       bubble_exe,
   input  logic                       bubble_mem,
   input  logic                       int_signal,
   input  logic                       eret_signal,
   output logic [EXC_TYPE_LENGTH-1:0] exc_type,
   output logic [5:0]                 hard_int,
   output logic                       flush,
   output logic                       busy
);

   exc_ctrl_state_e             state_q, state_d;
   logic [2:0]                  cnt_q, cnt_d;
   logic [EXC_TYPE_LENGTH-1:0]  exc_exe_q, exc_exe_d;
   logic [EXC_TYPE_LENGTH-1:0]  exc_mem_q, exc_mem_d;
   logic [5:0]                  pend_q, pend_d;
   logic [5:0]                  sync;

`ifdef EXC_CTRL_INT_SYNC_EN
   exc_ctrl_int_sync u_int_sync (
      .clk (clk),
      .rst (rst),
      .d   (hard_int_raw),
      .q   (sync)
   );
`else
   assign sync = hard_int_raw;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      flush   = 1'b0;
      busy    = 1'b0;
      case (state_q)
         EXC_CTRL_RUN: begin
            if (int_signal || eret_signal) begin
               state_d = EXC_CTRL_FLUSH;
               cnt_d   = 3'(FLUSH_CYCLES - 1);
            end
         end
         EXC_CTRL_FLUSH: begin
            flush = 1'b1;
            busy  = 1'b1;
            if (cnt_q == 3'd0) begin
               state_d = EXC_CTRL_RUN;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         default: state_d = EXC_CTRL_RUN;
      endcase
   end

   // ID-detected code takes precedence over the EXE-detected one for the same instruction
   always_comb begin
      exc_exe_d = exc_exe_q;
      exc_mem_d = exc_mem_q;
      if (flush) begin
         exc_exe_d = EXC_TYPE_NONE;
         exc_mem_d = EXC_TYPE_NONE;
      end else if (!stall) begin
         exc_exe_d = bubble_id ? EXC_TYPE_NONE : exc_id;
         if (bubble_exe) begin
            exc_mem_d = EXC_TYPE_NONE;
         end else begin
            exc_mem_d = (exc_exe_q != EXC_TYPE_NONE) ? exc_exe_q : exc_exe;
         end
      end
   end

   always_comb begin
      exc_type = EXC_TYPE_NONE;
      if (state_q == EXC_CTRL_FLUSH) begin
         exc_type = EXC_TYPE_NONE;
      end else if (!bubble_mem && (exc_mem_q != EXC_TYPE_NONE)) begin
         exc_type = exc_mem_q;
      end else if (pend_q != 6'd0) begin
         exc_type = EXC_TYPE_INT;
      end
   end

   // A taken interrupt clears pending bits; lines still asserted re-latch at once
   always_comb begin
      pend_d = pend_q | sync;
      if (int_signal && (exc_type == EXC_TYPE_INT)) begin
         pend_d = sync;
      end
   end

   assign hard_int = pend_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= EXC_CTRL_RUN;
         cnt_q     <= 3'd0;
         exc_exe_q <= EXC_TYPE_NONE;
         exc_mem_q <= EXC_TYPE_NONE;
         pend_q    <= 6'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         exc_exe_q <= exc_exe_d;
         exc_mem_q <= exc_mem_d;
         pend_q    <= pend_d;
      end
   end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb/tb_exc_ctrl.sv - directed self-checking bench for exc_ctrl
module tb_exc_ctrl;
   import exc_ctrl_pkg::*;

`ifdef EXC_CTRL_INT_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic                       clk;
   logic                       rst;
   logic [5:0]                 hard_int_raw;
   logic [EXC_TYPE_LENGTH-1:0] exc_id;
   logic [EXC_TYPE_LENGTH-1:0] exc_exe;
   logic                       stall;
   logic                       bubble_id;
   logic                       bubble_exe;
   logic                       bubble_mem;
   logic                       int_signal;
   logic                       eret_signal;
   logic [EXC_TYPE_LENGTH-1:0] exc_type;
   logic [5:0]                 hard_int;
   logic                       flush;
   logic                       busy;

   int tests;
   int fails;

   exc_ctrl #(.FLUSH_CYCLES(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .hard_int_raw (hard_int_raw),
      .exc_id       (exc_id),
      .exc_exe      (exc_exe),
      .stall        (stall),
      .bubble_id    (bubble_id),
      .bubble_exe   (bubble_exe),
      .bubble_mem   (bubble_mem),
      .int_signal   (int_signal),
      .eret_signal  (eret_signal),
      .exc_type     (exc_type),
      .hard_int     (hard_int),
      .flush        (flush),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      hard_int_raw = 6'd0;
      exc_id       = EXC_TYPE_NONE;
      exc_exe      = EXC_TYPE_NONE;
      stall        = 1'b0;
      bubble_id    = 1'b1;
      bubble_exe   = 1'b1;
      bubble_mem   = 1'b1;
      int_signal   = 1'b0;
      eret_signal  = 1'b0;
   endtask

   task automatic pulse_int(input logic [5:0] v);
      hard_int_raw = v;
      tick();
      hard_int_raw = 6'd0;
      repeat (LAT - 1) tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b0;
      #1;
      tests++; if (exc_type !== EXC_TYPE_NONE) begin fails++; $display("FAIL reset_exc_type got %h exp %h", exc_type, EXC_TYPE_NONE); end
      tests++; if (hard_int !== 6'd0) begin fails++; $display("FAIL reset_hard_int got %b exp 000000", hard_int); end
      tests++; if (flush !== 1'b0) begin fails++; $display("FAIL reset_flush got %b exp 0", flush); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
      #11 rst = 1'b1;
      tick();
   endtask

   task automatic test_ri_to_mem();
      bubble_id = 1'b0; exc_id = EXC_TYPE_RI;
      tick();
      bubble_id = 1'b1; exc_id = EXC_TYPE_NONE; bubble_exe = 1'b0;
      tick();
      bubble_exe = 1'b1; bubble_mem = 1'b0;
      #1;
      tests++; if (exc_type !== EXC_TYPE_RI) begin fails++; $display("FAIL ri_mem got %h exp %h", exc_type, EXC_TYPE_RI); end
      bubble_mem = 1'b1;
      #1;
      tests++; if (exc_type !== EXC_TYPE_NONE) begin fails++; $display("FAIL ri_bubble_mem got %h exp %h", exc_type, EXC_TYPE_NONE); end
      tick();
   endtask

   task automatic test_id_priority();
      bubble_id = 1'b0; exc_id = EXC_TYPE_SYS;
      tick();
      bubble_id = 1'b1; exc_id = EXC_TYPE_NONE; bubble_exe = 1'b0; exc_exe = EXC_TYPE_OV;
      tick();
      bubble_exe = 1'b1; exc_exe = EXC_TYPE_NONE; bubble_mem = 1'b0;
      #1;
      tests++; if (exc_type !== EXC_TYPE_SYS) begin fails++; $display("FAIL sys_over_ov got %h exp %h", exc_type, EXC_TYPE_SYS); end
      tick();
      bubble_exe = 1'b0; exc_exe = EXC_TYPE_TR;
      tick();
      bubble_exe = 1'b1; exc_exe = EXC_TYPE_NONE;
      #1;
      tests++; if (exc_type !== EXC_TYPE_TR) begin fails++; $display("FAIL exe_tr got %h exp %h", exc_type, EXC_TYPE_TR); end
      bubble_mem = 1'b1;
      tick();
   endtask

   task automatic test_interrupt();
      int nflush;
      pulse_int(6'b000100);
      tests++; if (hard_int !== 6'b000100) begin fails++; $display("FAIL int_latched got %b exp 000100", hard_int); end
      tests++; if (exc_type !== EXC_TYPE_INT) begin fails++; $display("FAIL int_type got %h exp %h", exc_type, EXC_TYPE_INT); end
      tick();
      tests++; if (hard_int !== 6'b000100) begin fails++; $display("FAIL int_sticky got %b exp 000100", hard_int); end
      int_signal = 1'b1;
      tick();
      int_signal = 1'b0;
      tests++; if (hard_int !== 6'd0) begin fails++; $display("FAIL int_cleared got %b exp 000000", hard_int); end
      tests++; if (exc_type !== EXC_TYPE_NONE) begin fails++; $display("FAIL flush_type got %h exp %h", exc_type, EXC_TYPE_NONE); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL flush_busy got %b exp 1", busy); end
      nflush = 0;
      for (int i = 0; i < 10 && flush; i++) begin
         nflush++;
         tick();
      end
      tests++; if (nflush != 2) begin fails++; $display("FAIL flush_len got %0d exp 2", nflush); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_done_busy got %b exp 0", busy); end
   endtask

   task automatic test_exc_over_int();
      pulse_int(6'b000001);
      bubble_exe = 1'b0; exc_exe = EXC_TYPE_OV;
      tick();
      bubble_exe = 1'b1; exc_exe = EXC_TYPE_NONE; stall = 1'b1; bubble_mem = 1'b0;
      #1;
      tests++; if (exc_type !== EXC_TYPE_OV) begin fails++; $display("FAIL ov_over_int got %h exp %h", exc_type, EXC_TYPE_OV); end
      int_signal = 1'b1;
      tick();
      int_signal = 1'b0;
      tests++; if (hard_int !== 6'b000001) begin fails++; $display("FAIL pend_kept got %b exp 000001", hard_int); end
      tests++; if (flush !== 1'b1) begin fails++; $display("FAIL ov_flush got %b exp 1", flush); end
      tick();
      tick();
      tests++; if (flush !== 1'b0) begin fails++; $display("FAIL ov_flush_end got %b exp 0", flush); end
      tests++; if (exc_type !== EXC_TYPE_INT) begin fails++; $display("FAIL int_after_flush got %h exp %h", exc_type, EXC_TYPE_INT); end
      int_signal = 1'b1;
      tick();
      int_signal = 1'b0;
      tests++; if (hard_int !== 6'd0) begin fails++; $display("FAIL pend_taken got %b exp 000000", hard_int); end
      tick();
      tick();
      stall = 1'b0; bubble_mem = 1'b1;
   endtask

   task automatic test_stall();
      bubble_id = 1'b0; exc_id = EXC_TYPE_RI;
      tick();
      stall = 1'b1; bubble_id = 1'b1; exc_id = EXC_TYPE_NONE; bubble_exe = 1'b0; bubble_mem = 1'b0;
      repeat (3) tick();
      tests++; if (exc_type !== EXC_TYPE_NONE) begin fails++; $display("FAIL stall_no_advance got %h exp %h", exc_type, EXC_TYPE_NONE); end
      stall = 1'b0;
      tick();
      tests++; if (exc_type !== EXC_TYPE_RI) begin fails++; $display("FAIL stall_held got %h exp %h", exc_type, EXC_TYPE_RI); end
      bubble_exe = 1'b1;
      tick();
      bubble_id = 1'b0; exc_id = EXC_TYPE_RI; bubble_mem = 1'b1;
      tick();
      bubble_id = 1'b1; exc_id = EXC_TYPE_NONE; bubble_exe = 1'b0;
      tick();
      stall = 1'b1; bubble_mem = 1'b0;
      bubble_id = 1'b0; exc_id = EXC_TYPE_SYS;
      tick();
      bubble_id = 1'b1; exc_id = EXC_TYPE_NONE;
      tests++; if (exc_type !== EXC_TYPE_RI) begin fails++; $display("FAIL stall_mem_ri got %h exp %h", exc_type, EXC_TYPE_RI); end
      int_signal = 1'b1;
      tick();
      int_signal = 1'b0;
      tick();
      tick();
      tests++; if (exc_type !== EXC_TYPE_NONE) begin fails++; $display("FAIL flush_clears_mem got %h exp %h", exc_type, EXC_TYPE_NONE); end
      stall = 1'b0;
      tick();
      tests++; if (exc_type !== EXC_TYPE_NONE) begin fails++; $display("FAIL flush_clears_exe got %h exp %h", exc_type, EXC_TYPE_NONE); end
      bubble_exe = 1'b1; bubble_mem = 1'b1;
      tick();
   endtask

   task automatic test_reset_mid_flush();
      pulse_int(6'b000010);
      eret_signal = 1'b1;
      tick();
      eret_signal = 1'b0;
      tests++; if (flush !== 1'b1) begin fails++; $display("FAIL eret_flush got %b exp 1", flush); end
      tests++; if (hard_int !== 6'b000010) begin fails++; $display("FAIL eret_keeps_pend got %b exp 000010", hard_int); end
      rst = 1'b0;
      #1;
      tests++; if (flush !== 1'b0) begin fails++; $display("FAIL async_rst_flush got %b exp 0", flush); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL async_rst_busy got %b exp 0", busy); end
      tests++; if (hard_int !== 6'd0) begin fails++; $display("FAIL async_rst_hard_int got %b exp 000000", hard_int); end
      tick();
      rst = 1'b1;
      tick();
      tests++; if (busy !== 1'b0 || flush !== 1'b0) begin fails++; $display("FAIL run_after_rst got busy=%b flush=%b exp 0 0", busy, flush); end
      tests++; if (exc_type !== EXC_TYPE_NONE) begin fails++; $display("FAIL type_after_rst got %h exp %h", exc_type, EXC_TYPE_NONE); end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_ri_to_mem();
      test_id_priority();
      test_interrupt();
      test_exc_over_int();
      test_stall();
      test_reset_mid_flush();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
